// File: rtl/rf_dbg_pkg.sv
// Shared constants for the register-file debug access controller:
// command opcodes, FSM state encoding and register-file geometry.
package rf_dbg_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [1:0] OP_DUMP  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;
    localparam logic [1:0] OP_WR    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_OUT   = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_dbg_ctrl.sv
// Debug access controller for the CPU register file write port and read
// port 2. Serves DUMP / CLEAR / RD / WR commands from a debug host, stalls
// the CPU while busy and streams read words out; in IDLE the CPU's write
// and read-2 signals pass straight through to the register file.
//
// Handshakes: both the command port (cmd_valid/cmd_ready) and the output
// stream (out_valid/out_ready) transfer on a rising edge where valid and
// ready are both high. Once out_valid rises, out_addr/out_data/out_last
// stay frozen until that transfer; out_valid never depends on out_ready
// combinationally. cmd_ready is high exactly when the FSM is IDLE.
module regfile_dbg_ctrl
    import rf_dbg_pkg::*;
#(
    parameter int NREG = rf_dbg_pkg::NREG,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          cpu_stall,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_waddr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [AW-1:0] cpu_raddr2,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata2,
    output state_t        dbg_state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          single_q;     // current read command is RD (one word)
    logic          out_valid_q;
    logic [AW-1:0] out_addr_q;
    logic [DW-1:0] out_data_q;
    logic          out_last_q;

    assign cmd_ready = (state_q == ST_IDLE);
    assign cpu_stall = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign dbg_state = state_q;

    // Command FSM: address walk, write-data latch and registered out stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            single_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_DUMP: begin
                                addr_q   <= '0;
                                single_q <= 1'b0;
                                state_q  <= ST_READ;
                            end
                            OP_RD: begin
                                addr_q   <= cmd_addr;
                                single_q <= 1'b1;
                                state_q  <= ST_READ;
                            end
                            OP_WR: begin
                                addr_q  <= cmd_addr;
                                wdata_q <= cmd_data;
                                state_q <= ST_WRITE;
                            end
                            default: begin
                                // CLEAR skips r0, which is hardwired to zero.
                                addr_q  <= AW'(1);
                                state_q <= ST_CLEAR;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    out_data_q  <= rf_rdata2;
                    out_addr_q  <= addr_q;
                    out_last_q  <= single_q || (addr_q == LAST_ADDR);
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            addr_q  <= addr_q + AW'(1);
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                    end else begin
                        addr_q <= addr_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Register-file port mux: CPU pass-through when idle, debug ownership otherwise.
    always_comb begin
        rf_we     = cpu_we;
        rf_waddr  = cpu_waddr;
        rf_wdata  = cpu_wdata;
        rf_raddr2 = cpu_raddr2;
        if (state_q != ST_IDLE) begin
            rf_we     = 1'b0;
            rf_waddr  = addr_q;
            rf_wdata  = '0;
            rf_raddr2 = addr_q;
            if (state_q == ST_WRITE) begin
                rf_we    = (addr_q != '0);
                rf_wdata = wdata_q;
            end else if (state_q == ST_CLEAR) begin
                rf_we = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Bench for regfile_dbg_ctrl: a behavioural 32x32 register file around the
// DUT, a reference array of expected register contents, and one task per
// scenario with inline comparisons.
module tb_regfile_dbg_ctrl;
  import rf_dbg_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [4:0]    cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          cpu_stall;
  logic          cpu_we;
  logic [4:0]    cpu_waddr;
  logic [DW-1:0] cpu_wdata;
  logic [4:0]    cpu_raddr2;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [4:0]    rf_raddr2;
  logic [DW-1:0] rf_rdata2;
  state_t        dbg_state;

  int checks   = 0;
  int failures = 0;

  regfile_dbg_ctrl #(.NREG(NR), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last),
    .cpu_stall(cpu_stall),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_raddr2(cpu_raddr2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file environment ----------------
  logic [DW-1:0] rf_mem [NR];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? '0 : rf_mem[rf_raddr2];
  always @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf_mem[rf_waddr] <= rf_wdata;
  end

  // ---------------- monitors (pre-edge values at each rising edge) ----------------
  int            cyc       = 0;
  int            stab_errs = 0;
  int            we0_cnt   = 0;
  int            stall_cnt = 0;
  logic          hold_q    = 1'b0;
  logic [4:0]    h_addr;
  logic [DW-1:0] h_data;
  logic          h_last;
  logic [4:0]    we_addr_q[$];
  logic [DW-1:0] we_data_q[$];
  int            we_cyc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q && (out_valid !== 1'b1 || out_addr !== h_addr ||
                     out_data !== h_data || out_last !== h_last))
        stab_errs <= stab_errs + 1;
      hold_q <= out_valid && !out_ready;
      h_addr <= out_addr;
      h_data <= out_data;
      h_last <= out_last;
      if (cpu_stall) stall_cnt <= stall_cnt + 1;
      if (rf_we) begin
        we_addr_q.push_back(rf_waddr);
        we_data_q.push_back(rf_wdata);
        we_cyc_q.push_back(cyc);
        if (rf_waddr == 5'd0) we0_cnt <= we0_cnt + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_rf [NR];
  logic [DW-1:0] exp_q[$];
  logic [4:0]    exp_a[$];
  logic [4:0]    got_a[$];
  logic [DW-1:0] got_d[$];
  logic          got_l[$];

  function automatic logic [DW-1:0] ref_read(input logic [4:0] a);
    return (a == 5'd0) ? '0 : exp_rf[a];
  endfunction

  // ---------------- drivers ----------------
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] a, input logic [DW-1:0] d);
    int w;
    w = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept op=%0d got_ready=%b exp_ready=1", op, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Accept words with probability pct% per cycle; returns at a falling edge
  // after the final handshake edge.
  task automatic collect(input int n, input int pct);
    int c;
    got_a.delete();
    got_d.delete();
    got_l.delete();
    c = 0;
    while (got_a.size() < n && c < n * 40 + 50) begin
      out_ready = ($urandom_range(99) < pct);
      if (out_valid && out_ready) begin
        got_a.push_back(out_addr);
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b0;
    checks++;
    if (got_a.size() != n) begin
      failures++;
      $display("FAIL collect_count got=%0d exp=%0d", got_a.size(), n);
    end
  endtask

  task automatic preload_ramp();
    for (int n = 1; n < NR; n++) begin
      do_cmd(OP_WR, 5'(n), n * 32'h0101_0101);
      exp_rf[n] = n * 32'h0101_0101;
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [DW-1:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_addr !== 5'd0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_out got=%b/%b/%0d/%h exp=0/0/0/0", out_valid, out_last, out_addr, out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || cpu_stall !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_idle got ready=%b stall=%b st=%0d exp 1 0 0", cmd_ready, cpu_stall, dbg_state);
    end
    d = $urandom;
    cpu_we = 1'b1;
    cpu_waddr = 5'd3;
    cpu_wdata = d;
    cpu_raddr2 = 5'd9;
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== d || rf_raddr2 !== 5'd9) begin
      failures++;
      $display("FAIL passthru got we=%b wa=%0d wd=%h ra=%0d exp 1 3 %h 9", rf_we, rf_waddr, rf_wdata, rf_raddr2, d);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    exp_rf[3] = d;
  endtask

  task automatic test_rd();
    int s0;
    do_cmd(OP_WR, 5'd5, 32'hDEAD_BEEF);
    exp_rf[5] = 32'hDEAD_BEEF;
    @(negedge clk);
    s0 = stall_cnt;
    do_cmd(OP_RD, 5'd5, '0);
    checks++;
    if (cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL rd_stall_e0 got=%b exp=1", cpu_stall);
    end
    collect(1, 100);
    checks++;
    if (got_a.size() == 1 && (got_a[0] !== 5'd5 || got_d[0] !== 32'hDEAD_BEEF || got_l[0] !== 1'b1)) begin
      failures++;
      $display("FAIL rd5_word got=%0d/%h/%b exp=5/deadbeef/1", got_a[0], got_d[0], got_l[0]);
    end
    checks++;
    if (stall_cnt - s0 != 2) begin
      failures++;
      $display("FAIL rd_stall_cycles got=%0d exp=2", stall_cnt - s0);
    end
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_done got valid=%b ready=%b exp 0 1", out_valid, cmd_ready);
    end
  endtask

  task automatic test_wr();
    int w0;
    do_cmd(OP_WR, 5'd7, 32'h1234_5678);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234_5678 || cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL wr_port got we=%b wa=%0d wd=%h stall=%b exp 1 7 12345678 1", rf_we, rf_waddr, rf_wdata, cpu_stall);
    end
    exp_rf[7] = 32'h1234_5678;
    do_cmd(OP_RD, 5'd7, '0);
    collect(1, 70);
    checks++;
    if (got_a.size() == 1 && (got_a[0] !== 5'd7 || got_d[0] !== ref_read(5'd7) || got_l[0] !== 1'b1)) begin
      failures++;
      $display("FAIL rd7_word got=%0d/%h/%b exp=7/%h/1", got_a[0], got_d[0], got_l[0], ref_read(5'd7));
    end
    w0 = we0_cnt;
    do_cmd(OP_WR, 5'd0, 32'hFFFF_FFFF);
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL wr0_we got=%b exp=0", rf_we);
    end
    do_cmd(OP_RD, 5'd0, '0);
    collect(1, 70);
    checks++;
    if (got_a.size() == 1 && (got_a[0] !== 5'd0 || got_d[0] !== '0 || got_l[0] !== 1'b1)) begin
      failures++;
      $display("FAIL rd0_word got=%0d/%h/%b exp=0/0/1", got_a[0], got_d[0], got_l[0]);
    end
    checks++;
    if (we0_cnt != w0) begin
      failures++;
      $display("FAIL we_addr0 got=%0d exp=%0d", we0_cnt, w0);
    end
  endtask

  task automatic test_dump(input int pct);
    int se;
    exp_q.delete();
    exp_a.delete();
    for (int i = 0; i < NR; i++) begin
      exp_a.push_back(5'(i));
      exp_q.push_back(ref_read(5'(i)));
    end
    se = stab_errs;
    do_cmd(OP_DUMP, 5'd0, '0);
    collect(NR, pct);
    for (int i = 0; i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_q[i] || got_l[i] !== (i == NR - 1)) begin
        failures++;
        $display("FAIL dump_word%0d got=%0d/%h/%b exp=%0d/%h/%b", i, got_a[i], got_d[i], got_l[i],
                 exp_a[i], exp_q[i], (i == NR - 1));
      end
    end
    checks++;
    if (stab_errs != se) begin
      failures++;
      $display("FAIL out_stable got=%0d exp=%0d", stab_errs - se, 0);
    end
  endtask

  task automatic test_busy_cmd();
    logic [DW-1:0] d;
    int bad;
    d = $urandom;
    bad = 0;
    do_cmd(OP_RD, 5'd20, '0);
    cmd_valid = 1'b1;
    cmd_op    = OP_WR;
    cmd_addr  = 5'd11;
    cmd_data  = d;
    repeat (4) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || rf_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_ignore got=%0d exp=0", bad);
    end
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 5'd20 || out_data !== ref_read(5'd20) || out_last !== 1'b1) begin
      failures++;
      $display("FAIL busy_word got=%b/%0d/%h/%b exp=1/20/%h/1", out_valid, out_addr, out_data, out_last, ref_read(5'd20));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL busy_first_idle got ready=%b valid=%b exp 1 0", cmd_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== d) begin
      failures++;
      $display("FAIL busy_accept got ready=%b we=%b wa=%0d wd=%h exp 0 1 11 %h", cmd_ready, rf_we, rf_waddr, rf_wdata, d);
    end
    cmd_valid = 1'b0;
    exp_rf[11] = d;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int idx;
    int n;
    logic [DW-1:0] cd;
    cd = 32'hA5A5_0009;
    idx = we_addr_q.size();
    do_cmd(OP_CLEAR, 5'd0, '0);
    cpu_we = 1'b1;
    cpu_waddr = 5'd9;
    cpu_wdata = cd;
    checks++;
    if (cpu_stall !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_busy got stall=%b ready=%b exp 1 0", cpu_stall, cmd_ready);
    end
    repeat (31) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      failures++;
      $display("FAIL clear_idle_passthru got ready=%b we=%b wa=%0d exp 1 1 9", cmd_ready, rf_we, rf_waddr);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    for (int i = 1; i < NR; i++) exp_rf[i] = '0;
    exp_rf[9] = cd;
    n = we_addr_q.size() - idx;
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL clear_write_count got=%0d exp=32", n);
    end else begin
      for (int i = 0; i < 31; i++) begin
        checks++;
        if (we_addr_q[idx+i] !== 5'(i + 1) || we_data_q[idx+i] !== '0 || we_cyc_q[idx+i] != we_cyc_q[idx] + i) begin
          failures++;
          $display("FAIL clear_write%0d got=%0d/%h exp=%0d/0", i, we_addr_q[idx+i], we_data_q[idx+i], i + 1);
        end
      end
      checks++;
      if (we_addr_q[idx+31] !== 5'd9 || we_data_q[idx+31] !== cd) begin
        failures++;
        $display("FAIL clear_cpu_after got=%0d/%h exp=9/%h", we_addr_q[idx+31], we_data_q[idx+31], cd);
      end
    end
    test_dump(60);
  endtask

  task automatic test_reset_mid();
    do_cmd(OP_DUMP, 5'd0, '0);
    collect(10, 100);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 5'd10) begin
      failures++;
      $display("FAIL mid_word10 got=%b/%0d exp=1/10", out_valid, out_addr);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1 || cpu_stall !== 1'b0 || out_addr !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset got valid=%b ready=%b stall=%b oa=%0d exp 0 1 0 0", out_valid, cmd_ready, cpu_stall, out_addr);
    end
    do_cmd(OP_RD, 5'd3, '0);
    collect(1, 50);
    checks++;
    if (got_a.size() == 1 && (got_a[0] !== 5'd3 || got_d[0] !== ref_read(5'd3) || got_l[0] !== 1'b1)) begin
      failures++;
      $display("FAIL mid_rd3 got=%0d/%h/%b exp=3/%h/1", got_a[0], got_d[0], got_l[0], ref_read(5'd3));
    end
  endtask

  task automatic test_random();
    logic [4:0]    a;
    logic [DW-1:0] d;
    for (int k = 0; k < 24; k++) begin
      a = 5'($urandom_range(31));
      d = $urandom;
      if ($urandom_range(1) == 0) begin
        do_cmd(OP_WR, a, d);
        if (a != 5'd0) exp_rf[a] = d;
      end else begin
        do_cmd(OP_RD, a, '0);
        collect(1, $urandom_range(100, 30));
        checks++;
        if (got_a.size() == 1 && (got_a[0] !== a || got_d[0] !== ref_read(a) || got_l[0] !== 1'b1)) begin
          failures++;
          $display("FAIL rand_rd%0d got=%0d/%h/%b exp=%0d/%h/1", k, got_a[0], got_d[0], got_l[0], a, ref_read(a));
        end
      end
    end
    test_dump(50);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = OP_DUMP;
    cmd_addr = '0;
    cmd_data = '0;
    out_ready = 1'b0;
    cpu_we = 1'b0;
    cpu_waddr = '0;
    cpu_wdata = '0;
    cpu_raddr2 = '0;
    for (int i = 0; i < NR; i++) exp_rf[i] = '0;
    test_reset();
    test_rd();
    test_wr();
    preload_ramp();
    test_dump(50);
    test_busy_cmd();
    test_clear();
    preload_ramp();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dbg_ctrl.md
# regfile_dbg_ctrl

Debug access controller that sits on the write port and read port 2 of the 32x32 CPU register file. It serves commands from a debug host: dump all registers, clear all registers, single read, single write. While a command runs it stalls the CPU and takes over those ports. Read data goes out over a valid/ready stream; when idle, the CPU's write and read-2 signals pass through unchanged.

## Interface
Parameters
- NREG, 32, register count; address width is 5 bits.
- DW, 32, data width.

Ports
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_op  in  2  00 DUMP, 01 CLEAR, 10 RD, 11 WR.
- cmd_addr  in  5  address for RD/WR.
- cmd_data  in  DW  data for WR.
- out_valid  out  1  read word available.
- out_ready  in  1  consumer accepts the word.
- out_addr  out  5  register index of the current word.
- out_data  out  DW  register contents.
- out_last  out  1  final word of a command.
- cpu_stall  out  1  CPU must freeze.
- cpu_we, cpu_waddr[4:0], cpu_wdata[DW-1:0]  in  CPU write request.
- cpu_raddr2  in  5  CPU read-port-2 address.
- rf_we, rf_waddr[4:0], rf_wdata[DW-1:0]  out  to the register file write port.
- rf_raddr2  out  5  to register file read port 2.
- rf_rdata2  in  DW  combinational read data from the register file.

## Operation
- States: IDLE, READ, OUT, WRITE, CLEAR. An internal 5-bit counter `addr` holds the current register index.
- IDLE:
  - cmd_ready=1, cpu_stall=0.
  - rf_* = cpu_*, rf_raddr2=cpu_raddr2.
  - On accept:
    - DUMP → addr=0, READ.
    - RD → addr=cmd_addr, READ.
    - WR → addr=cmd_addr, data latched, WRITE.
    - CLEAR → addr=1, CLEAR.
- Any state other than IDLE:
  - cpu_stall=1, cmd_ready=0.
  - rf_raddr2=addr.
  - CPU writes are dropped (rf_we driven only by this block).
- READ: capture out_data=rf_rdata2, out_addr=addr, out_valid=1. out_last=1 if the command is RD or addr==31. Next state OUT.
- OUT:
  - Hold out_* stable until out_ready.
  - On handshake: out_valid=0. If last → IDLE; otherwise addr+1 → READ.
- WRITE:
  - rf_we=(addr!=0), rf_waddr=addr, rf_wdata=latched data. Next state IDLE.
  - WR to address 0 completes with no write.
- CLEAR: rf_we=1, rf_wdata=0, rf_waddr=addr. Increment addr; after address 31, go to IDLE. Covers 31 writes, addresses 1..31.
- Address 0 read returns 0, because the register file forces zero on that address.
- Reset: state=IDLE, out_valid=0, out_last=0, out_addr=0, out_data=0, addr=0. cmd_ready becomes 1 and cpu_stall 0 as soon as reset is released.
- Reset mid-command:
  - The command is aborted immediately.
  - Register-file contents are not restored, so a partial CLEAR leaves registers 1..k zeroed.
  - A pending out word is discarded.

## Timing
- Command accepted at edge E0 → cpu_stall high from E0.
- RD/DUMP: first out_valid after E1. Minimum 2 cycles per word, so a DUMP with out_ready held high takes 64 cycles.
- WR: write occurs at edge E1; IDLE after E1.
- CLEAR: writes at edges E1..E31; IDLE after E31.
- out_valid never drops without a handshake, and out_data/out_addr/out_last are stable while valid.
- cmd_valid during busy: ignored (cmd_ready=0); the host holds it.
- rf_raddr2 and the rf_we/rf_waddr/rf_wdata mux are combinational from the state register. There is no combinational path from out_ready to out_valid.
- Counter wrap: addr never increments past 31. The last-word check uses addr==31 before increment.

## Structure
- Package `rf_dbg_pkg`:
  - Opcode localparams OP_DUMP, OP_CLEAR, OP_RD, OP_WR.
  - State enum encoding.
  - NREG and address width.
- Single module. No sub-module is warranted; the port mux is inline.

## Test plan
- Preload r5=0xDEADBEEF. RD addr 5 → one out word: addr 5, data 0xDEADBEEF, last=1. cpu_stall high for exactly 2 cycles plus any out_ready wait.
- WR addr 7 data 0x12345678, then RD 7 → 0x12345678. WR addr 0 data 0xFFFFFFFF, then RD 0 → 0; rf_we never asserted with waddr 0.
- Preload rN=N·0x01010101. DUMP with out_ready random (~50%) → 32 words, addr 0..31, data 0 then N·0x01010101. last only on addr 31. Fields stable while out_valid is high and out_ready is low.
- CLEAR → 31 consecutive rf_we cycles at addresses 1..31, then DUMP → all zeros. cpu_we=1 during CLEAR never reaches rf_we; with cpu_we held, it passes through once IDLE.
- Assert rst mid-DUMP at word 10 → out_valid=0 and cmd_ready=1 as soon as rst is released. A new RD 3 command then works normally.
- cmd_valid held high during a busy command with a different op → not accepted until IDLE; accepted on the first IDLE cycle.
